// File: rtl/usbdev_pkg.sv
// usbdev_pkg: shared state and reason-bit definitions for the usbdev AON wake controller
package usbdev_pkg;
  typedef enum logic [2:0] {
    AwcIdle    = 3'd0,
    AwcArm     = 3'd1,
    AwcMonitor = 3'd2,
    AwcWake    = 3'd3,
    AwcRelease = 3'd4
  } aon_wake_ctrl_state_e;
  localparam int AwcReasonNotIdle   = 0;
  localparam int AwcReasonReset     = 1;
  localparam int AwcReasonSenseLost = 2;
endpackage

// File: rtl/usbdev_aon_wake_ctrl.sv
// usbdev_aon_wake_ctrl: sequences the AON wake detector handshake, latches wake reason, supervises timeouts.
//   clk_aon_i/rst_aon_i                      AON clock, async active-high reset
//   suspend_en_i, resume_ack_i, clr_err_i    synced AON register controls
//   wake_detect_active_i, wake_req_i,
//   bus_not_idle_i, bus_reset_i, sense_lost_i detector status and event flags
//   suspend_req_aon_o, wake_ack_aon_o        handshake to the detector
//   wake_irq_o, wake_reason_o, timeout_err_o status to software; state_o debug
module usbdev_aon_wake_ctrl
  import usbdev_pkg::*;
#(
  parameter int ArmTimeoutCycles     = 16,
  parameter int ReleaseTimeoutCycles = 16,
  parameter int HoldoffCycles        = 8
) (
  input  logic       clk_aon_i,
  input  logic       rst_aon_i,
  input  logic       suspend_en_i,
  input  logic       resume_ack_i,
  input  logic       clr_err_i,
  input  logic       wake_detect_active_i,
  input  logic       wake_req_i,
  input  logic       bus_not_idle_i,
  input  logic       bus_reset_i,
  input  logic       sense_lost_i,
  output logic       suspend_req_aon_o,
  output logic       wake_ack_aon_o,
  output logic       wake_irq_o,
  output logic [2:0] wake_reason_o,
  output logic       timeout_err_o,
  output logic [2:0] state_o
);
  localparam int MaxAh     = ArmTimeoutCycles > HoldoffCycles ? ArmTimeoutCycles : HoldoffCycles;
  localparam int MaxCycles = ReleaseTimeoutCycles > MaxAh ? ReleaseTimeoutCycles : MaxAh;
  localparam int CntW      = $clog2(MaxCycles) + 1;
  aon_wake_ctrl_state_e r_state, w_next;
  logic [CntW-1:0] r_cnt;
  logic            r_holdoff;
  logic            r_suspend_req, r_wake_ack, r_wake_irq, r_timeout_err;
  logic [2:0]      r_wake_reason;
  logic            w_timeout;
  logic [2:0]      w_flags;
  always_comb begin
    w_flags = '0;
    w_flags[AwcReasonNotIdle]   = bus_not_idle_i;
    w_flags[AwcReasonReset]     = bus_reset_i;
    w_flags[AwcReasonSenseLost] = sense_lost_i;
  end
  // r_holdoff is only set by leaving RELEASE, so the first arm after reset is not delayed
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      AwcIdle:
        if (suspend_en_i && (!r_holdoff || r_cnt >= CntW'(HoldoffCycles))) w_next = AwcArm;
      AwcArm:
        if (wake_detect_active_i) w_next = AwcMonitor;
        else if (!suspend_en_i) w_next = AwcRelease;
        else if (r_cnt == CntW'(ArmTimeoutCycles - 1)) begin
          w_next    = AwcRelease;
          w_timeout = 1'b1;
        end
      AwcMonitor:
        if (wake_req_i) w_next = AwcWake;
        else if (!suspend_en_i) w_next = AwcRelease;
      AwcWake:
        if (resume_ack_i) w_next = AwcRelease;
      AwcRelease:
        if (!wake_detect_active_i) w_next = AwcIdle;
        else if (r_cnt == CntW'(ReleaseTimeoutCycles - 1)) begin
          w_next    = AwcIdle;
          w_timeout = 1'b1;
        end
      default: w_next = AwcIdle;
    endcase
  end
  // outputs are registered from the next state so they line up with state_o
  always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
    if (rst_aon_i) begin
      r_state       <= AwcIdle;
      r_cnt         <= '0;
      r_holdoff     <= 1'b0;
      r_suspend_req <= 1'b0;
      r_wake_ack    <= 1'b0;
      r_wake_irq    <= 1'b0;
      r_wake_reason <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= (w_next != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
      r_holdoff     <= (w_next == AwcIdle) && (r_holdoff || r_state == AwcRelease);
      r_suspend_req <= (w_next == AwcArm) || (w_next == AwcMonitor);
      r_wake_ack    <= w_next == AwcRelease;
      r_wake_irq    <= w_next == AwcWake;
      r_wake_reason <= (w_next == AwcArm && r_state != AwcArm) ? '0 :
                       (w_next == AwcWake) ? (r_wake_reason | w_flags) : r_wake_reason;
      r_timeout_err <= w_timeout | (r_timeout_err & ~clr_err_i);
    end
  end
  assign suspend_req_aon_o = r_suspend_req;
  assign wake_ack_aon_o    = r_wake_ack;
  assign wake_irq_o        = r_wake_irq;
  assign wake_reason_o     = r_wake_reason;
  assign timeout_err_o     = r_timeout_err;
  assign state_o           = r_state;
endmodule

// File: tb/tb_usbdev_aon_wake_ctrl.sv
// tb_usbdev_aon_wake_ctrl: directed plus randomized checks of the AON wake controller against a behavioural model
module tb_usbdev_aon_wake_ctrl;
  logic       clk = 1'b0, rst = 1'b0;
  logic       suspend_en = 1'b0, resume_ack = 1'b0, clr_err = 1'b0;
  logic       active = 1'b0, wake_req = 1'b0, bus_not_idle = 1'b0, bus_reset = 1'b0, sense_lost = 1'b0;
  logic       suspend_req, wake_ack, wake_irq, timeout_err;
  logic [2:0] wake_reason, state;
  int vectors = 0, miscompares = 0;
  int m_state, m_cnt, m_since_rel;
  logic [2:0] m_reason;
  logic m_err;
  int sr_cnt = 0, ack_cnt = 0;
  bit det_auto = 1'b0;
  always #5 clk = ~clk;
  usbdev_aon_wake_ctrl dut (
    .clk_aon_i(clk), .rst_aon_i(rst), .suspend_en_i(suspend_en), .resume_ack_i(resume_ack),
    .clr_err_i(clr_err), .wake_detect_active_i(active), .wake_req_i(wake_req),
    .bus_not_idle_i(bus_not_idle), .bus_reset_i(bus_reset), .sense_lost_i(sense_lost),
    .suspend_req_aon_o(suspend_req), .wake_ack_aon_o(wake_ack), .wake_irq_o(wake_irq),
    .wake_reason_o(wake_reason), .timeout_err_o(timeout_err), .state_o(state)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_since_rel = 1 << 20; m_reason = '0; m_err = 1'b0;
  endtask
  // one clock of the handshake rules: 0 idle, 1 arm, 2 monitor, 3 wake, 4 release
  task automatic model_step();
    int ns;
    bit to;
    ns = m_state; to = 1'b0;
    if (m_state == 0 && suspend_en && m_since_rel >= 8) ns = 1;
    if (m_state == 1) begin
      if (active) ns = 2;
      else if (!suspend_en) ns = 4;
      else if (m_cnt == 15) begin ns = 4; to = 1'b1; end
    end
    if (m_state == 2) ns = wake_req ? 3 : (suspend_en ? 2 : 4);
    if (m_state == 3 && resume_ack) ns = 4;
    if (m_state == 4) begin
      if (!active) ns = 0;
      else if (m_cnt == 15) begin ns = 0; to = 1'b1; end
    end
    if (ns == 1 && m_state != 1) m_reason = '0;
    if (ns == 3) m_reason = m_reason | {sense_lost, bus_reset, bus_not_idle};
    m_err = to ? 1'b1 : (clr_err ? 1'b0 : m_err);
    if (m_state == 4 && ns == 0) m_since_rel = 0;
    else if (ns == 0 && m_since_rel < (1 << 20)) m_since_rel++;
    m_cnt = (ns != m_state) ? 0 : (m_cnt < 31 ? m_cnt + 1 : 31);
    m_state = ns;
  endtask
  task automatic check_all();
    chk("state", {5'd0, state}, 8'(m_state));
    chk("suspend_req", {7'd0, suspend_req}, {7'd0, m_state == 1 || m_state == 2});
    chk("wake_ack", {7'd0, wake_ack}, {7'd0, m_state == 4});
    chk("wake_irq", {7'd0, wake_irq}, {7'd0, m_state == 3});
    chk("wake_reason", {5'd0, wake_reason}, {5'd0, m_reason});
    chk("timeout_err", {7'd0, timeout_err}, {7'd0, m_err});
  endtask
  // detector model: goes active 2 cycles after suspend_req, inactive 2 cycles after wake_ack
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
    if (det_auto) begin
      sr_cnt  = suspend_req ? sr_cnt + 1 : 0;
      ack_cnt = wake_ack ? ack_cnt + 1 : 0;
      if (sr_cnt >= 2) active = 1'b1;
      if (ack_cnt >= 2) active = 1'b0;
    end
  endtask
  task automatic wait_state(input logic [2:0] s, input int lim);
    for (int i = 0; i < lim && state !== s; i++) tick();
    chk("wait_state", {5'd0, state}, {5'd0, s});
  endtask
  initial begin
    rst = 1'b1;
    model_reset();
    #1 check_all();
    tick();
    rst = 1'b0;
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_reason", {5'd0, wake_reason}, 8'd0);
    det_auto = 1'b1; suspend_en = 1'b1;
    tick();
    chk("t1_arm", {5'd0, state}, 8'd1);
    chk("t1_sreq", {7'd0, suspend_req}, 8'd1);
    tick(); tick();
    chk("t1_monitor", {5'd0, state}, 8'd2);
    wake_req = 1'b1; bus_reset = 1'b1;
    tick();
    wake_req = 1'b0; bus_reset = 1'b0;
    chk("t2_irq", {7'd0, wake_irq}, 8'd1);
    chk("t2_reason", {5'd0, wake_reason}, 8'b010);
    tick();
    resume_ack = 1'b1;
    tick();
    resume_ack = 1'b0;
    chk("t2_ack", {7'd0, wake_ack}, 8'd1);
    wait_state(3'd0, 20);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_holdoff", {5'd0, state}, 8'd0);
    end
    tick();
    chk("t2_rearm", {5'd0, state}, 8'd1);
    wait_state(3'd2, 10);
    suspend_en = 1'b0;
    tick();
    chk("t5_release", {5'd0, state}, 8'd4);
    chk("t5_reason", {5'd0, wake_reason}, 8'd0);
    chk("t5_irq", {7'd0, wake_irq}, 8'd0);
    wait_state(3'd0, 20);
    det_auto = 1'b0; active = 1'b0; suspend_en = 1'b1;
    wait_state(3'd1, 20);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t3_arm_hold", {5'd0, state}, 8'd1);
    end
    tick();
    chk("t3_timeout_state", {5'd0, state}, 8'd4);
    chk("t3_err", {7'd0, timeout_err}, 8'd1);
    clr_err = 1'b1; suspend_en = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("t3_clr", {7'd0, timeout_err}, 8'd0);
    active = 1'b1; suspend_en = 1'b1;
    wait_state(3'd2, 20);
    suspend_en = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("rel_hold", {5'd0, state}, 8'd4);
    end
    tick();
    chk("rel_timeout_state", {5'd0, state}, 8'd0);
    chk("rel_timeout_err", {7'd0, timeout_err}, 8'd1);
    chk("rel_ack_drop", {7'd0, wake_ack}, 8'd0);
    active = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    det_auto = 1'b1; suspend_en = 1'b1;
    wait_state(3'd2, 40);
    wake_req = 1'b1; suspend_en = 1'b0; bus_not_idle = 1'b1;
    tick();
    wake_req = 1'b0; bus_not_idle = 1'b0;
    chk("t4_wake", {5'd0, state}, 8'd3);
    chk("t4_irq", {7'd0, wake_irq}, 8'd1);
    chk("t4_reason", {5'd0, wake_reason}, 8'b001);
    tick();
    chk("t4_ignore_en", {5'd0, state}, 8'd3);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_state", {5'd0, state}, 8'd0);
    chk("t6_irq", {7'd0, wake_irq}, 8'd0);
    check_all();
    tick();
    rst = 1'b0; suspend_en = 1'b1;
    tick();
    chk("t6_arm", {5'd0, state}, 8'd1);
    for (int blk = 0; blk < 50; blk++) begin
      det_auto = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 64; i++) begin
        suspend_en   = $urandom_range(0, 9) != 0;
        wake_req     = $urandom_range(0, 11) == 0;
        bus_not_idle = 1'($urandom_range(0, 1));
        bus_reset    = $urandom_range(0, 3) == 0;
        sense_lost   = $urandom_range(0, 3) == 0;
        resume_ack   = $urandom_range(0, 5) == 0;
        clr_err      = $urandom_range(0, 15) == 0;
        if (!det_auto) active = $urandom_range(0, 7) != 0 ? active : ~active;
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          model_reset();
          #1 check_all();
          tick();
          rst = 1'b0;
        end
        tick();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
